// File: rtl/priority_class_demux.sv
// Priority class demultiplexer: routes a tagged AXI-Stream onto one of four
// traffic-class queues through a single output register slice. The class is
// taken from the first beat's priority field and held for the whole packet.
// Per-queue egress packet counters count completed packets.
module priority_class_demux #(
    parameter int C_DATA_WIDTH  = 256,
    parameter int C_TUSER_WIDTH = 128,
    parameter int PRIO_LSB      = 32
) (
    input  logic                      clk,
    input  logic                      rst,

    input  logic [C_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [C_DATA_WIDTH/8-1:0] s_axis_tkeep,
    input  logic [C_TUSER_WIDTH-1:0]  s_axis_tuser,
    input  logic                      s_axis_tvalid,
    input  logic                      s_axis_tlast,
    output logic                      s_axis_tready,

    output logic [C_DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [C_DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic [C_TUSER_WIDTH-1:0]  m_axis_tuser,
    output logic                      m_axis_tlast,
    output logic [3:0]                m_axis_tvalid,
    input  logic [3:0]                m_axis_tready,

    output logic [127:0]              pkt_count
);

    typedef enum logic {
        IDLE,
        IN_PKT
    } state_t;

    state_t                     state_q, state_d;
    logic [1:0]                 class_q, class_d;
    logic [1:0]                 out_class_q, out_class_d;
    logic [3:0]                 tvalid_q, tvalid_d;
    logic                       last_q, last_d;
    logic [C_DATA_WIDTH-1:0]    data_q, data_d;
    logic [C_DATA_WIDTH/8-1:0]  keep_q, keep_d;
    logic [C_TUSER_WIDTH-1:0]   user_q, user_d;
    logic [127:0]               cnt_q, cnt_d;

    logic                       out_full;
    logic                       out_fire;
    logic                       in_fire;
    logic [1:0]                 beat_class;

    // Handshake decode: the slot frees up when the selected queue takes the held beat.
    always_comb begin
        out_full      = |tvalid_q;
        out_fire      = out_full & m_axis_tready[out_class_q];
        s_axis_tready = ~rst & (~out_full | m_axis_tready[out_class_q]);
        in_fire       = s_axis_tvalid & s_axis_tready;
        beat_class    = (state_q == IDLE) ? s_axis_tuser[PRIO_LSB+1 +: 2] : class_q;
    end

    // Next-state logic for the packet FSM, the output slice and the counters.
    always_comb begin
        state_d     = state_q;
        class_d     = class_q;
        out_class_d = out_class_q;
        tvalid_d    = tvalid_q;
        last_d      = last_q;
        data_d      = data_q;
        keep_d      = keep_q;
        user_d      = user_q;
        cnt_d       = cnt_q;

        if (in_fire) begin
            data_d      = s_axis_tdata;
            keep_d      = s_axis_tkeep;
            user_d      = s_axis_tuser;
            last_d      = s_axis_tlast;
            out_class_d = beat_class;
            tvalid_d    = 4'b0001 << beat_class;
            if (state_q == IDLE) begin
                class_d = beat_class;
                state_d = s_axis_tlast ? IDLE : IN_PKT;
            end else if (s_axis_tlast) begin
                state_d = IDLE;
            end
        end else if (out_fire) begin
            tvalid_d = 4'b0000;
        end

        if (out_fire && last_q) begin
            cnt_d[32*out_class_q +: 32] = cnt_q[32*out_class_q +: 32] + 32'd1;
        end
    end

    // Control state, valid flags and counters; all cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            class_q     <= 2'd0;
            out_class_q <= 2'd0;
            tvalid_q    <= 4'b0000;
            last_q      <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            class_q     <= class_d;
            out_class_q <= out_class_d;
            tvalid_q    <= tvalid_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
        end
    end

    // Payload register needs no reset; it is only observed while a valid bit is set.
    always_ff @(posedge clk) begin
        data_q <= data_d;
        keep_q <= keep_d;
        user_q <= user_d;
    end

    assign m_axis_tdata  = data_q;
    assign m_axis_tkeep  = keep_q;
    assign m_axis_tuser  = user_q;
    assign m_axis_tlast  = last_q;
    assign m_axis_tvalid = tvalid_q;
    assign pkt_count     = cnt_q;

endmodule

// File: tb/tb_priority_class_demux.sv
// Self-checking bench for priority_class_demux: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the held beat and per-queue packet totals.
module tb_priority_class_demux;

    localparam int DW = 256;
    localparam int UW = 128;
    localparam int KW = DW / 8;
    localparam int PL = 32;

    logic            clk = 1'b0;
    logic            rst;
    logic [DW-1:0]   s_axis_tdata;
    logic [KW-1:0]   s_axis_tkeep;
    logic [UW-1:0]   s_axis_tuser;
    logic            s_axis_tvalid;
    logic            s_axis_tlast;
    logic            s_axis_tready;
    logic [DW-1:0]   m_axis_tdata;
    logic [KW-1:0]   m_axis_tkeep;
    logic [UW-1:0]   m_axis_tuser;
    logic            m_axis_tlast;
    logic [3:0]      m_axis_tvalid;
    logic [3:0]      m_axis_tready;
    logic [127:0]    pkt_count;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic [UW-1:0] user;
        logic          last;
        logic [1:0]    cls;
    } beat_t;

    // Model: at most one beat is held; packet totals per queue.
    bit          model_ok = 0;
    bit          m_held;
    beat_t       m_beat;
    bit          m_inpkt;
    logic [1:0]  m_pkt_cls;
    logic [31:0] m_cnt [4];
    bit          m_acc;

    priority_class_demux #(
        .C_DATA_WIDTH (DW),
        .C_TUSER_WIDTH(UW),
        .PRIO_LSB     (PL)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .s_axis_tdata (s_axis_tdata),
        .s_axis_tkeep (s_axis_tkeep),
        .s_axis_tuser (s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast (s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata (m_axis_tdata),
        .m_axis_tkeep (m_axis_tkeep),
        .m_axis_tuser (m_axis_tuser),
        .m_axis_tlast (m_axis_tlast),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .pkt_count    (pkt_count)
    );

    // Free-running clock, 10 time-unit period.
    always #5 clk = ~clk;

    // Single comparison primitive; every check in the bench goes through here.
    task automatic compare(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] randData();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [UW-1:0] randUser(input int prio);
        logic [UW-1:0] r;
        for (int i = 0; i < UW / 32; i++) r[i*32 +: 32] = $urandom;
        r[PL +: 3] = 3'(prio);
        return r;
    endfunction

    // The input side is ready when not in reset and the slot is free or draining.
    function automatic bit expReady();
        return !rst && (!m_held || m_axis_tready[m_beat.cls] == 1'b1);
    endfunction

    // Compare every DUT output against the model state.
    task automatic checkOutput();
        compare("s_axis_tready", s_axis_tready, expReady());
        compare("m_axis_tvalid", m_axis_tvalid, m_held ? 4'(1 << m_beat.cls) : 4'b0000);
        if (m_held) begin
            compare("m_axis_tdata", m_axis_tdata, m_beat.data);
            compare("m_axis_tkeep", m_axis_tkeep, m_beat.keep);
            compare("m_axis_tuser", m_axis_tuser, m_beat.user);
            compare("m_axis_tlast", m_axis_tlast, m_beat.last);
        end
        for (int q = 0; q < 4; q++) compare($sformatf("pkt_count[%0d]", q), pkt_count[32*q +: 32], m_cnt[q]);
    endtask

    // Advance the model by one clock using only the bench-driven inputs.
    task automatic modelUpdate();
        bit         fire_out;
        bit         acc;
        logic [1:0] c;
        m_acc = 0;
        if (rst) begin
            m_held   = 0;
            m_inpkt  = 0;
            for (int q = 0; q < 4; q++) m_cnt[q] = 32'd0;
            model_ok = 1;
        end else begin
            fire_out = m_held && m_axis_tready[m_beat.cls] == 1'b1;
            acc      = s_axis_tvalid && expReady();
            if (fire_out && m_beat.last) m_cnt[m_beat.cls] += 32'd1;
            if (acc) begin
                c         = m_inpkt ? m_pkt_cls : 2'(s_axis_tuser[PL +: 3] / 2);
                m_beat    = '{s_axis_tdata, s_axis_tkeep, s_axis_tuser, s_axis_tlast, c};
                m_held    = 1;
                m_inpkt   = !s_axis_tlast;
                m_pkt_cls = c;
            end else if (fire_out) begin
                m_held = 0;
            end
            m_acc = acc;
        end
    endtask

    // One clock: check just after the inputs settle, update the model at the edge.
    task automatic cycle();
        #1;
        if (model_ok) checkOutput();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
    endtask

    task automatic applyStimulus(input bit v, input logic [DW-1:0] d, input logic [KW-1:0] k,
                                 input logic [UW-1:0] u, input bit l, input bit r);
        s_axis_tvalid = v;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tuser  = u;
        s_axis_tlast  = l;
        rst           = r;
    endtask

    // Offer one beat until accepted, with a bounded wait; returns cycles spent.
    task automatic sendBeat(input int prio, input bit last, output int used);
        applyStimulus(1, randData(), KW'($urandom), randUser(prio), last, 0);
        used = 0;
        do begin
            cycle();
            used++;
        end while (!m_acc && used < 20);
        if (!m_acc) compare("accept timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        applyStimulus(0, '0, '0, '0, 0, 0);
        repeat (n) cycle();
    endtask

    int          used;
    logic [DW-1:0] held_data;

    initial begin
        m_axis_tready = 4'b1111;
        applyStimulus(0, '0, '0, '0, 0, 1);
        @(negedge clk);
        cycle();
        cycle();

        // Reset values.
        compare("reset tvalid", m_axis_tvalid, 4'b0000);
        compare("reset s_tready", s_axis_tready, 1'b0);
        compare("reset tlast", m_axis_tlast, 1'b0);
        compare("reset pkt_count", pkt_count, 128'd0);
        rst = 0;
        #1 compare("ready after reset", s_axis_tready, 1'b1);

        // 4-beat packet at priority 7 lands on queue 3 every cycle.
        for (int i = 0; i < 4; i++) begin
            sendBeat(7, i == 3, used);
            compare("p7 tvalid", m_axis_tvalid, 4'b1000);
        end
        idle(1);
        compare("p7 pkt_count[3]", pkt_count[127:96], 32'd1);

        // Back-to-back single-beat packets, one per queue, no bubbles.
        sendBeat(0, 1, used); compare("b2b q0", m_axis_tvalid, 4'b0001); compare("b2b cycles", used, 1);
        sendBeat(3, 1, used); compare("b2b q1", m_axis_tvalid, 4'b0010); compare("b2b cycles", used, 1);
        sendBeat(4, 1, used); compare("b2b q2", m_axis_tvalid, 4'b0100); compare("b2b cycles", used, 1);
        sendBeat(6, 1, used); compare("b2b q3", m_axis_tvalid, 4'b1000); compare("b2b cycles", used, 1);
        idle(1);
        compare("b2b counts", pkt_count, {32'd2, 32'd1, 32'd1, 32'd1});

        // Queue 1 stalled for 5 cycles while unrelated queues are ready.
        m_axis_tready = 4'b1101;
        sendBeat(2, 0, used);
        held_data = m_beat.data;
        compare("stall tready", s_axis_tready, 1'b0);
        applyStimulus(1, randData(), '1, randUser(2), 0, 0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            compare("stall tready", s_axis_tready, 1'b0);
            compare("stall tvalid", m_axis_tvalid, 4'b0010);
            compare("stall tdata", m_axis_tdata, held_data);
        end
        m_axis_tready = 4'b1111;
        sendBeat(2, 0, used);
        sendBeat(2, 1, used);
        idle(1);
        compare("stall pkt_count[1]", pkt_count[63:32], 32'd2);

        // Priority changes mid-packet are ignored.
        sendBeat(1, 0, used); compare("latch beat0", m_axis_tvalid, 4'b0001);
        sendBeat(7, 0, used); compare("latch beat1", m_axis_tvalid, 4'b0001);
        sendBeat(7, 1, used); compare("latch beat2", m_axis_tvalid, 4'b0001);
        idle(1);

        // Reset mid-packet discards it; the next beat starts a new packet.
        sendBeat(3, 0, used);
        sendBeat(3, 0, used);
        applyStimulus(0, '0, '0, '0, 0, 1);
        cycle();
        compare("midrst tvalid", m_axis_tvalid, 4'b0000);
        compare("midrst tlast", m_axis_tlast, 1'b0);
        compare("midrst pkt_count", pkt_count, 128'd0);
        rst = 0;
        #1 compare("midrst ready", s_axis_tready, 1'b1);
        sendBeat(5, 0, used); compare("after rst beat0", m_axis_tvalid, 4'b0100);
        sendBeat(5, 1, used); compare("after rst beat1", m_axis_tvalid, 4'b0100);
        idle(1);
        compare("after rst pkt_count[2]", pkt_count[95:64], 32'd1);

        // Counter wrap on queue 0.
        dut.cnt_q[31:0] = 32'hFFFF_FFFF;
        m_cnt[0]        = 32'hFFFF_FFFF;
        sendBeat(0, 1, used);
        idle(1);
        compare("wrap pkt_count[0]", pkt_count[31:0], 32'd0);

        // Randomized traffic with backpressure and occasional reset.
        for (int n = 0; n < 3000; n++) begin
            if (!s_axis_tvalid || m_acc || rst) begin
                applyStimulus(($urandom % 10) < 7, randData(), KW'($urandom),
                              randUser($urandom % 8), ($urandom % 4) == 0, 0);
            end
            rst = ($urandom % 250) == 0;
            for (int q = 0; q < 4; q++) m_axis_tready[q] = ($urandom % 4) != 0;
            cycle();
        end
        idle(3);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
